// File: rtl/led_scan_defs.sv
// led_scan_defs: shared scanner state encodings and a constant-safe clog2.
package led_scan_defs;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ACTIVE, S_BLANK, S_TEST} state_t;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int x = v - 1; x > 0; x = x >> 1) r++;
      return r;
   endfunction
endpackage

// File: rtl/row_decode_n.sv
// row_decode_n: active-low one-hot row decoder; all ones when disabled or idx is out of range.
module row_decode_n #(
   parameter int ROWS = 8,
   parameter int W = 3
) (
   input  logic            en,
   input  logic [W-1:0]    idx,
   output logic [ROWS-1:0] row_n
);
   always_comb
      for (int i = 0; i < ROWS; i++) row_n[i] = !(en && idx == W'(i));
endmodule

// File: rtl/led_row_scanner.sv
// led_row_scanner: row-scan driver with per-row dwell, inter-row blanking and a static test mode.
module led_row_scanner
   import led_scan_defs::*;
#(
   parameter int ROWS = 8,
   parameter int DWELL = 1000,
   parameter int BLANK = 16,
   localparam int ROW_W = clog2(ROWS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             test_en,
   input  logic [ROW_W-1:0] test_row,
   output logic [ROWS-1:0]  row_n,
   output logic [ROW_W-1:0] row_idx,
   output logic             row_load,
   output logic             frame_start
);
   localparam int DB = DWELL > BLANK ? DWELL : BLANK;
   localparam int CW = clog2(DB > 2 ? DB : 2);
   localparam logic [CW-1:0] DMAX = CW'(DWELL - 1);
   localparam logic [CW-1:0] BMAX = CW'(BLANK > 0 ? BLANK - 1 : 0);
   state_t state, ns;
   logic [CW-1:0] cnt, ncnt;
   logic [ROW_W-1:0] nidx;
   logic [ROWS-1:0] dec_n;
   always_comb begin
      ns = state;
      nidx = row_idx;
      ncnt = '0;
      if (test_en) begin
         ns = S_TEST;
         nidx = '0;
      end else if (state == S_TEST || !en) begin
         ns = S_IDLE;
         nidx = '0;
      end else if (state == S_IDLE) ns = S_LOAD;
      else if (state == S_LOAD) ns = S_ACTIVE;
      else if (state == S_ACTIVE) begin
         if (cnt == DMAX) begin
            ns = BLANK > 0 ? S_BLANK : S_LOAD;
            nidx = row_idx == ROW_W'(ROWS - 1) ? '0 : row_idx + 1'b1;
         end else ncnt = cnt + 1'b1;
      end else begin
         if (cnt == BMAX) ns = S_LOAD;
         else ncnt = cnt + 1'b1;
      end
   end
   // Outputs are decoded from the next state so every output is a plain register.
   row_decode_n #(.ROWS(ROWS), .W(ROW_W)) u_dec (
      .en   (ns == S_ACTIVE || ns == S_TEST),
      .idx  (ns == S_TEST ? test_row : nidx),
      .row_n(dec_n)
   );
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= S_IDLE;
         cnt <= '0;
         row_idx <= '0;
         row_n <= '1;
         row_load <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         state <= ns;
         cnt <= ncnt;
         row_idx <= nidx;
         row_n <= dec_n;
         row_load <= ns == S_LOAD;
         frame_start <= ns == S_LOAD && nidx == '0;
      end
endmodule
